// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants, scan state type and digit one-hot helper for the
// 4-digit multiplexed 7-segment display scanner.
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEL_W      = 2;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  function automatic logic [NUM_DIGITS-1:0] onehot4(input logic [SEL_W-1:0] s);
    logic [NUM_DIGITS-1:0] r;
    r    = '0;
    r[s] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_tick_gen.sv
// Slot prescaler: counts 0..PRESCALE-1 while enabled, holds when disabled,
// and flags the terminal-count cycle as the scan advance strobe.
module tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic adv
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_reg, cnt_next;

  // With PRESCALE=1 the counter sits at 0 == LAST, so every enabled cycle advances.
  assign adv = enable && (cnt_reg == LAST);

  always_comb begin
    cnt_next = cnt_reg;
    if (enable) begin
      cnt_next = adv ? '0 : cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Digit scan controller: registered digit select, active-low anodes and advance tick.
// Define SCAN_BLANK_EN to add anode dead-time (BLANK state) after each digit change.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [SEL_W-1:0]      sel,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  tick
);

  logic                  adv;
  logic [SEL_W-1:0]      sel_reg, sel_next;
  logic [NUM_DIGITS-1:0] an_reg, an_next, an_show;
  logic                  tick_reg, tick_next;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .adv   (adv)
  );

`ifdef SCAN_BLANK_EN
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  scan_state_t    state_reg, state_next;
  logic [BW-1:0]  blank_reg, blank_next;
`endif

  always_comb begin
    sel_next  = sel_reg;
    tick_next = adv;
    if (adv) begin
      sel_next = sel_reg + SEL_W'(1);
    end
    // Anodes follow the select being loaded this edge, so both switch together.
    an_show = ~(onehot4(sel_next) & digit_en);
`ifdef SCAN_BLANK_EN
    state_next = state_reg;
    blank_next = blank_reg;
    an_next    = an_show;
    if (adv) begin
      state_next = BLANK;
      blank_next = '0;
      an_next    = AN_OFF;
    end else if (state_reg == BLANK) begin
      an_next = AN_OFF;
      if (blank_reg == BLANK_LAST) begin
        state_next = SHOW;
        an_next    = an_show;
      end else begin
        blank_next = blank_reg + BW'(1);
      end
    end
`else
    an_next = an_show;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_reg   <= '0;
      an_reg    <= AN_OFF;
      tick_reg  <= 1'b0;
`ifdef SCAN_BLANK_EN
      state_reg <= SHOW;
      blank_reg <= '0;
`endif
    end else begin
      sel_reg   <= sel_next;
      an_reg    <= an_next;
      tick_reg  <= tick_next;
`ifdef SCAN_BLANK_EN
      state_reg <= state_next;
      blank_reg <= blank_next;
`endif
    end
  end

  assign sel  = sel_reg;
  assign an   = an_reg;
  assign tick = tick_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: vector table, scoreboard model, corner sequences.
module tb_display_scan_ctrl;

  localparam int P = 4;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] digit_en = 4'hF;
  logic [1:0] sel, sel1;
  logic [3:0] an, an1;
  logic       tick, tick1;

  always #5 clk = ~clk;

  display_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .enable(enable), .digit_en(digit_en),
    .sel(sel), .an(an), .tick(tick)
  );

  display_scan_ctrl #(.PRESCALE(1), .BLANK_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .digit_en(digit_en),
    .sel(sel1), .an(an1), .tick(tick1)
  );

  typedef struct {
    logic [1:0] sel;
    logic [3:0] an;
    logic       tick;
  } exp_t;

  typedef struct {
    logic       en;
    logic [3:0] den;
    logic [1:0] sel;
    logic [3:0] an;
    logic       tick;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];

  int errors = 0;
  int checks = 0;

  // Reference model state (mirrors the DUT's visible state after each edge)
  int         m_cnt = 0;
  int         m_sel = 0;
  int         m_rem = 0;
  logic [3:0] m_an  = 4'hF;
  logic       m_tick = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic e, input logic [3:0] d);
    logic       a;
    logic [3:0] show;
    if (r) begin
      m_cnt = 0; m_sel = 0; m_an = 4'hF; m_tick = 1'b0; m_rem = 0;
    end else begin
      a = e && (m_cnt == P - 1);
      if (e) m_cnt = a ? 0 : m_cnt + 1;
      if (a) m_sel = (m_sel + 1) % 4;
      m_tick = a;
      show = 4'hF ^ ((4'b0001 << m_sel) & d);
`ifdef SCAN_BLANK_EN
      if (a) begin
        m_rem = B;
        m_an  = 4'hF;
      end else if (m_rem > 0) begin
        m_rem--;
        m_an = (m_rem == 0) ? show : 4'hF;
      end else begin
        m_an = show;
      end
`else
      m_an = show;
`endif
    end
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare after the edge.
  task automatic step(input logic r, input logic e, input logic [3:0] d);
    exp_t x;
    logic [3:0] low;
    reset = r; enable = e; digit_en = d;
    model(r, e, d);
    x.sel = 2'(m_sel); x.an = m_an; x.tick = m_tick;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk("sb_sel", int'(sel), int'(x.sel));
    chk("sb_an", int'(an), int'(x.an));
    chk("sb_tick", int'(tick), int'(x.tick));
    low = ~an;
    chk("an_onehot", int'($countones(low) <= 1), 1);
  endtask

  task automatic run_to(input int s, input int c, input string name);
    int n;
    n = 0;
    while (!(m_sel == s && m_cnt == c) && n < 40) begin
      step(1'b0, 1'b1, 4'hF);
      n++;
    end
    chk({name, "_reach"}, int'(m_sel == s && m_cnt == c), 1);
  endtask

  task automatic add_vec(input logic e, input logic [3:0] d, input logic [1:0] s,
                         input logic [3:0] a, input logic t);
    vec_t v;
    v.en = e; v.den = d; v.sel = s; v.an = a; v.tick = t;
    vecs.push_back(v);
  endtask

  task automatic add_slot(input logic [3:0] d, input logic [1:0] s, input logic [3:0] a);
    add_vec(1'b1, d, s, a, 1'b1);
    for (int k = 0; k < 3; k++) add_vec(1'b1, d, s, a, 1'b0);
  endtask

  initial begin
    // Full scan with all digits on, then a scan with DIGIT_EN=1010
    for (int k = 0; k < 3; k++) add_vec(1'b1, 4'hF, 2'd0, 4'b1110, 1'b0);
    add_slot(4'hF, 2'd1, 4'b1101);
    add_slot(4'hF, 2'd2, 4'b1011);
    add_slot(4'hF, 2'd3, 4'b0111);
    add_slot(4'hF, 2'd0, 4'b1110);
    add_slot(4'hA, 2'd1, 4'b1101);
    add_slot(4'hA, 2'd2, 4'b1111);
    add_slot(4'hA, 2'd3, 4'b0111);
    add_slot(4'hA, 2'd0, 4'b1111);

    step(1'b1, 1'b0, 4'hF);
    step(1'b1, 1'b1, 4'hF);
    chk("rst_sel", int'(sel), 0);
    chk("rst_an", int'(an), 4'hF);
    chk("rst_tick", int'(tick), 0);

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].en, vecs[i].den);
      chk("vec_sel", int'(sel), int'(vecs[i].sel));
      chk("vec_tick", int'(tick), int'(vecs[i].tick));
`ifndef SCAN_BLANK_EN
      chk("vec_an", int'(an), int'(vecs[i].an));
`endif
    end

    // Freeze with ENABLE low at prescaler=2, SEL=1
    run_to(1, 2, "freeze");
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 4'hF);
      chk("hold_sel", int'(sel), 1);
      chk("hold_an", int'(an), 4'b1101);
      chk("hold_tick", int'(tick), 0);
    end
    step(1'b0, 1'b1, 4'hF);
    chk("reen1_tick", int'(tick), 0);
    step(1'b0, 1'b1, 4'hF);
    chk("reen2_tick", int'(tick), 1);
    chk("reen2_sel", int'(sel), 2);

    // Reset mid-slot with SEL=3, then a full 4-cycle slot on digit 0
    run_to(3, 1, "midrst");
    step(1'b1, 1'b1, 4'hF);
    chk("midrst_sel", int'(sel), 0);
    chk("midrst_an", int'(an), 4'hF);
    chk("midrst_tick", int'(tick), 0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b1, 4'hF);
      chk("restart_sel", int'(sel), (k == 4) ? 1 : 0);
      chk("restart_tick", int'(tick), (k == 4) ? 1 : 0);
    end

    // Reset coinciding with terminal count
    run_to(2, 3, "rsttc");
    step(1'b1, 1'b1, 4'hF);
    chk("rsttc_sel", int'(sel), 0);
    chk("rsttc_tick", int'(tick), 0);

    // Digit enable all off: anodes dark, scan keeps stepping
    step(1'b0, 1'b1, 4'h0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 4'h0);
      chk("den0_an", int'(an), 4'hF);
    end
    chk("den0_sel", int'(sel), 1);

`ifdef SCAN_BLANK_EN
    run_to(1, 3, "blank");
    step(1'b0, 1'b1, 4'hF);
    chk("blank0_sel", int'(sel), 2);
    chk("blank0_an", int'(an), 4'hF);
    chk("blank0_tick", int'(tick), 1);
    step(1'b0, 1'b1, 4'hF);
    chk("blank1_an", int'(an), 4'hF);
    step(1'b0, 1'b1, 4'hF);
    chk("show0_an", int'(an), 4'b1011);
    step(1'b0, 1'b1, 4'hF);
    chk("show1_an", int'(an), 4'b1011);
`else
    // PRESCALE=1 instance: advance every enabled cycle
    step(1'b1, 1'b0, 4'hF);
    chk("p1_rst_sel", int'(sel1), 0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b1, 4'hF);
      chk("p1_sel", int'(sel1), k % 4);
      chk("p1_tick", int'(tick1), 1);
      chk("p1_an", int'(an1), int'(4'hF ^ (4'b0001 << (k % 4))));
    end
    step(1'b0, 1'b0, 4'hF);
    chk("p1_hold_tick", int'(tick1), 0);
    chk("p1_hold_sel", int'(sel1), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
